// File: rtl/alu_addsub_arbiter.sv
// alu_addsub_arbiter
// Shares one add/subtract unit between two requesters. In IDLE one requester is
// granted (round-robin or fixed priority), its operands are latched, the sum and
// Y86 condition codes are computed in EXEC, and the registered result is held in
// RESP until the owning requester accepts it.
module alu_addsub_arbiter #(
    parameter int WIDTH = 64,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic             req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zf,
    output logic             rsp_sf,
    output logic             rsp_of,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             owner_r;
    logic             last_r;        // requester served most recently
    logic             gnt_s;
    logic [1:0]       req_ready_s;
    logic             acc_s;
    logic             rsp_hs_s;
    logic [WIDTH:0]   alu_s;         // {of, sum}
    logic [WIDTH-1:0] result_r;
    logic             zf_r;
    logic             sf_r;
    logic             of_r;
    logic [1:0]       rsp_valid_r;
    logic             busy_r;

    // a + (op ? ~b : b) + op, split so the carry into the MSB is visible for OF.
    function automatic logic [WIDTH:0] addsub(input logic op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] lo;
        logic [1:0]       hi;
        bx = op ? ~b : b;
        lo = {1'b0, a[WIDTH-2:0]} + {1'b0, bx[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, op};
        hi = {1'b0, a[WIDTH-1]} + {1'b0, bx[WIDTH-1]} + {1'b0, lo[WIDTH-1]};
        return {hi[1] ^ lo[WIDTH-1], hi[0], lo[WIDTH-2:0]};
    endfunction

    // Pick the winning requester; on contention alternate or favour requester 0.
    always_comb begin
        gnt_s = 1'b0;
        if (req_valid == 2'b11) begin
            gnt_s = RR_EN ? ~last_r : 1'b0;
        end else if (req_valid[1]) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
    end

    // Accept strobe toward the winner, only while idle.
    always_comb begin
        req_ready_s = 2'b00;
        if ((state_r == IDLE) && (req_valid != 2'b00)) begin
            req_ready_s = gnt_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    assign acc_s    = |(req_valid & req_ready_s);
    assign rsp_hs_s = (state_r == RESP) && (owner_r ? rsp_ready[1] : rsp_ready[0]);
    assign alu_s    = addsub(op_r, a_r, b_r);

    // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (acc_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Latch operands and owner on the request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= 1'b0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            owner_r <= 1'b0;
        end else if (acc_s) begin
            op_r    <= gnt_s ? req1_op : req0_op;
            a_r     <= gnt_s ? req1_a  : req0_a;
            b_r     <= gnt_s ? req1_b  : req0_b;
            owner_r <= gnt_s;
        end else begin
            op_r    <= op_r;
            a_r     <= a_r;
            b_r     <= b_r;
            owner_r <= owner_r;
        end
    end

    // Capture result and flags at the end of EXEC; they persist afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
            zf_r     <= 1'b0;
            sf_r     <= 1'b0;
            of_r     <= 1'b0;
        end else if (state_r == EXEC) begin
            result_r <= alu_s[WIDTH-1:0];
            zf_r     <= (alu_s[WIDTH-1:0] == {WIDTH{1'b0}});
            sf_r     <= alu_s[WIDTH-1];
            of_r     <= alu_s[WIDTH];
        end else begin
            result_r <= result_r;
            zf_r     <= zf_r;
            sf_r     <= sf_r;
            of_r     <= of_r;
        end
    end

    // One-hot response valid, raised entering RESP and dropped on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 2'b00;
        end else if (state_r == EXEC) begin
            rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
        end else if (rsp_hs_s) begin
            rsp_valid_r <= 2'b00;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    // Round-robin history: remember who was served once the response completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (rsp_hs_s) begin
            last_r <= owner_r;
        end else begin
            last_r <= last_r;
        end
    end

    assign req_ready  = req_ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = result_r;
    assign rsp_zf     = zf_r;
    assign rsp_sf     = sf_r;
    assign rsp_of     = of_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_alu_addsub_arbiter.sv
// Directed bench for alu_addsub_arbiter: vector table plus reset, stall,
// arbitration and abandoned-transaction sequences.
module tb_alu_addsub_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        req0_op;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic        req1_op;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_zf;
    logic        rsp_sf;
    logic        rsp_of;
    logic        busy;

    logic [1:0]  fp_req_ready;
    logic [1:0]  fp_rsp_valid;
    logic [63:0] fp_rsp_result;
    logic        fp_rsp_zf;
    logic        fp_rsp_sf;
    logic        fp_rsp_of;
    logic        fp_busy;

    int checks = 0;
    int errors = 0;

    alu_addsub_arbiter #(.WIDTH(64), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .rsp_of(rsp_of), .busy(busy)
    );

    alu_addsub_arbiter #(.WIDTH(64), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(fp_rsp_result),
        .rsp_zf(fp_rsp_zf), .rsp_sf(fp_rsp_sf), .rsp_of(fp_rsp_of), .busy(fp_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          req;
        logic        op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        zf;
        logic        sf;
        logic        of;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic op, input logic [63:0] a, input logic [63:0] b);
        if (r == 0) begin
            req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic chk_flags(input string tag, input logic [63:0] res,
                             input logic zf, input logic sf, input logic of);
        chk({tag, " result"}, rsp_result, res);
        chk({tag, " zf"}, {63'd0, rsp_zf}, {63'd0, zf});
        chk({tag, " sf"}, {63'd0, rsp_sf}, {63'd0, sf});
        chk({tag, " of"}, {63'd0, rsp_of}, {63'd0, of});
    endtask

    // Full transaction at fixed latency; called one time unit after a rising edge.
    task automatic txn(input string tag, input logic [1:0] v, input logic keep,
                       input logic [1:0] gnt, input logic [63:0] res,
                       input logic zf, input logic sf, input logic of);
        req_valid = v;
        #1;
        chk({tag, " req_ready"}, {62'd0, req_ready}, {62'd0, gnt});
        chk({tag, " idle busy"}, {63'd0, busy}, 64'd0);
        tick();
        if (!keep) req_valid = 2'b00;
        chk({tag, " exec busy"}, {63'd0, busy}, 64'd1);
        chk({tag, " exec req_ready"}, {62'd0, req_ready}, 64'd0);
        chk({tag, " exec rsp_valid"}, {62'd0, rsp_valid}, 64'd0);
        tick();
        chk({tag, " rsp_valid"}, {62'd0, rsp_valid}, {62'd0, gnt});
        chk_flags(tag, res, zf, sf, of);
        rsp_ready = 2'b11;
        tick();
        rsp_ready = 2'b00;
        chk({tag, " done rsp_valid"}, {62'd0, rsp_valid}, 64'd0);
        chk({tag, " done busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{0, 1'b1, 64'd10, 64'd3, 64'd7, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{0, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{0, 1'b1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1, 1'b0, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{0, 1'b1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{0, 1'b0, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_1333, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req0_op = 1'b0; req0_a = 64'd0; req0_b = 64'd0;
        req1_op = 1'b0; req1_a = 64'd0; req1_b = 64'd0;

        // Power-up reset.
        #2 rst_n = 1'b0;
        #1;
        chk("reset rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("reset result", rsp_result, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset req_ready", {62'd0, req_ready}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post-reset req_ready a", {62'd0, req_ready}, 64'd0);
        tick();
        chk("post-reset req_ready b", {62'd0, req_ready}, 64'd0);

        // Reset asserted mid-stream while a result is pending.
        set_req(0, 1'b0, 64'd40, 64'd2);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        chk("midrst pre rsp_valid", {62'd0, rsp_valid}, 64'd1);
        chk("midrst pre result", rsp_result, 64'd42);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk_flags("midrst", 64'd0, 1'b0, 1'b0, 1'b0);
        chk("midrst busy", {63'd0, busy}, 64'd0);
        chk("midrst req_ready", {62'd0, req_ready}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst release req_ready", {62'd0, req_ready}, 64'd0);

        // Vector table: single requester, arithmetic and flag corners.
        for (int i = 0; i < 10; i++) begin
            set_req(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b);
            txn($sformatf("vec%0d", i), (vecs[i].req == 0) ? 2'b01 : 2'b10, 1'b0,
                (vecs[i].req == 0) ? 2'b01 : 2'b10,
                vecs[i].res, vecs[i].zf, vecs[i].sf, vecs[i].of);
        end

        // Response stall: result held, non-owner rsp_ready ignored.
        set_req(1, 1'b0, 64'h10, 64'h20);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d rsp_valid", i), {62'd0, rsp_valid}, 64'd2);
            chk_flags($sformatf("stall%0d", i), 64'h30, 1'b0, 1'b0, 1'b0);
            chk($sformatf("stall%0d req_ready", i), {62'd0, req_ready}, 64'd0);
            chk($sformatf("stall%0d busy", i), {63'd0, busy}, 64'd1);
            tick();
        end
        rsp_ready = 2'b01;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("nonowner%0d rsp_valid", i), {62'd0, rsp_valid}, 64'd2);
            chk($sformatf("nonowner%0d result", i), rsp_result, 64'h30);
            tick();
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        chk("stall done rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("stall rr next grant", {62'd0, req_ready}, 64'd1);
        req_valid = 2'b00;
        tick();
        chk("drop valid busy", {63'd0, busy}, 64'd0);
        chk("drop valid rsp_valid", {62'd0, rsp_valid}, 64'd0);

        // Contention with both requesters held valid.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        set_req(0, 1'b0, 64'd1, 64'd2);
        set_req(1, 1'b1, 64'd9, 64'd4);
        for (int i = 0; i < 4; i++) begin
            req_valid = 2'b11;
            #1;
            chk($sformatf("fixed prio grant%0d", i), {62'd0, fp_req_ready}, 64'd1);
            if ((i % 2) == 0)
                txn($sformatf("rr%0d", i), 2'b11, 1'b1, 2'b01, 64'd3, 1'b0, 1'b0, 1'b0);
            else
                txn($sformatf("rr%0d", i), 2'b11, 1'b1, 2'b10, 64'd5, 1'b0, 1'b0, 1'b0);
            chk($sformatf("fixed prio result%0d", i), fp_rsp_result, 64'd3);
        end
        req_valid = 2'b00;
        tick();

        // Reset pulsed while requester 1 is in EXEC.
        set_req(1, 1'b1, 64'd100, 64'd1);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        chk("abandon exec busy", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abandon busy", {63'd0, busy}, 64'd0);
        tick();
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abandon%0d rsp_valid", i), {62'd0, rsp_valid}, 64'd0);
            chk($sformatf("abandon%0d result", i), rsp_result, 64'd0);
        end
        rsp_ready = 2'b00;
        txn("post-abandon", 2'b11, 1'b0, 2'b01, 64'd3, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
